// File: rtl/vec_lane_reduce.sv
// Horizontal fp16 lane reducer: sums the 16 lanes of a packed vector in fixed order.
// Latency: out_valid rises LANES-1 edges after the accepting edge; one vector per LANES+1 cycles.
// Backpressure: in_ready only in IDLE; sum/out_valid held in DONE until out_ready.
//
// Ports: clk/rst_n (sync active-low), in_vec/in_mask/in_valid/in_ready (input handshake),
//        sum/out_valid/out_ready (output handshake), busy (ACC or DONE).
// ip_add_no_latency: combinational IEEE fp16 adder, round-to-nearest-even, subnormals kept.

module ip_add_no_latency (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic [15:0] big, sml;
  logic [5:0]  el, es, d, e, sh;
  logic [10:0] ml, ms;
  logic [13:0] xl, xs, n;
  logic [14:0] s;
  logic [3:0]  lz;
  logic [11:0] m12;
  logic        eff_sub, lost, rnd, hidden;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [9:0]  mant;

  always_comb begin
    nan_a = (&a[14:10]) & (|a[9:0]);
    nan_b = (&b[14:10]) & (|b[9:0]);
    inf_a = (&a[14:10]) & ~(|a[9:0]);
    inf_b = (&b[14:10]) & ~(|b[9:0]);

    // Order operands by magnitude so the subtraction below never goes negative.
    big = (a[14:0] >= b[14:0]) ? a : b;
    sml = (a[14:0] >= b[14:0]) ? b : a;
    el  = (big[14:10] == 5'd0) ? 6'd1 : {1'b0, big[14:10]};
    es  = (sml[14:10] == 5'd0) ? 6'd1 : {1'b0, sml[14:10]};
    ml  = {|big[14:10], big[9:0]};
    ms  = {|sml[14:10], sml[9:0]};
    d   = el - es;

    // Three extra low bits (guard/round/sticky); shifted-out bits jam into bit 0.
    xl   = {ml, 3'b000};
    xs   = {13'd0, |ms};
    lost = 1'b0;
    if (d < 6'd14) begin
      xs    = {ms, 3'b000} >> d;
      lost  = (({ms, 3'b000}) & ~(14'h3FFF << d)) != 14'd0;
      xs[0] = xs[0] | lost;
    end

    eff_sub = big[15] ^ sml[15];
    s = eff_sub ? ({1'b0, xl} - {1'b0, xs}) : ({1'b0, xl} + {1'b0, xs});

    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (s[i]) lz = 4'(13 - i);
    end

    // Carry-out shifts right; otherwise shift left, but never below the subnormal exponent.
    sh = 6'd0;
    e  = el;
    n  = s[13:0];
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      e = el + 6'd1;
    end else begin
      sh = ({2'b00, lz} > (el - 6'd1)) ? (el - 6'd1) : {2'b00, lz};
      n  = s[13:0] << sh;
      e  = el - sh;
    end

    rnd = n[2] & (n[1] | n[0] | n[3]);
    m12 = {1'b0, n[13:3]} + {11'd0, rnd};
    if (m12[11]) begin
      mant   = 10'd0;
      hidden = 1'b1;
      e      = e + 6'd1;
    end else begin
      mant   = m12[9:0];
      hidden = m12[10];
    end

    if (s == 15'd0) begin
      // Exact cancellation gives +0; only (-0)+(-0) keeps the sign.
      y = {~eff_sub & big[15], 15'd0};
    end else if (hidden && e >= 6'd31) begin
      y = {big[15], 15'h7C00};
    end else begin
      y = {big[15], (hidden ? e[4:0] : 5'd0), mant};
    end

    if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15]))) y = 16'h7E00;
    else if (inf_a) y = a;
    else if (inf_b) y = b;
  end
endmodule

module vec_lane_reduce #(
  parameter int LANES = 16,
  parameter int W     = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES*W-1:0] in_vec,
  input  logic [LANES-1:0]   in_mask,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W-1:0]       sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANES*W-1:0] vec_q, vec_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       lane_b, lane0_in, add_y;

  // Operands come only from the latched copy, so upstream may change in_vec after acceptance.
  assign lane_b   = mask_q[cnt_q] ? vec_q[cnt_q*W +: W] : '0;
  assign lane0_in = in_mask[0] ? in_vec[W-1:0] : '0;

  ip_add_no_latency u_add (
    .a (acc_q),
    .b (lane_b),
    .y (add_y)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          vec_d   = in_vec;
          mask_d  = in_mask;
          acc_d   = lane0_in;
          cnt_d   = CNT_W'(1);
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (cnt_q == CNT_W'(LANES - 1)) begin
          sum_d       = add_y;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_DONE;
        end else begin
          acc_d = add_y;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_vec_lane_reduce.sv
// Scoreboard bench for vec_lane_reduce: expected sums come from a real-arithmetic fp16 model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is bounded.

module tb_vec_lane_reduce;
  localparam int LANES = 16;
  localparam int W     = 16;

  logic               clk;
  logic               rst_n;
  logic [LANES*W-1:0] in_vec;
  logic [LANES-1:0]   in_mask;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       sum;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  vec_lane_reduce #(.LANES(LANES), .W(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_mask   (in_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- fp16 reference model (exact real add, then RNE to fp16) ----------------
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e, f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) v = f * $pow(2.0, -24.0);
    else        v = (1024 + f) * $pow(2.0, e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x, input logic neg_zero);
    real  ax, q, k, fl;
    int   ef, bits;
    logic sg;
    sg = (x < 0.0);
    ax = sg ? -x : x;
    if (ax == 0.0) return neg_zero ? 16'h8000 : 16'h0000;
    ef = 0;
    for (int e = 30; e >= 1; e--) if (ef == 0 && ax >= $pow(2.0, e - 15)) ef = e;
    q  = (ef == 0) ? $pow(2.0, -24.0) : $pow(2.0, ef - 25);
    k  = ax / q;
    fl = $floor(k);
    if ((k - fl > 0.5) || ((k - fl == 0.5) && ($rtoi(fl) % 2 == 1))) fl = fl + 1.0;
    bits = (ef == 0) ? $rtoi(fl) : (ef - 1) * 1024 + $rtoi(fl);
    if (bits >= 31744) bits = 31744;
    return {sg, 15'(bits)};
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b), a[15] & b[15]);
  endfunction

  function automatic logic [15:0] model_reduce(input logic [255:0] v, input logic [15:0] m);
    logic [15:0] acc, ln;
    acc = m[0] ? v[15:0] : 16'h0000;
    for (int i = 1; i < 16; i++) begin
      ln  = m[i] ? v[i*16 +: 16] : 16'h0000;
      acc = fp16_add(acc, ln);
    end
    return acc;
  endfunction

  function automatic logic [15:0] rand_lane();
    logic [15:0] h;
    h[15]    = 1'($urandom_range(0, 1));
    h[14:10] = 5'($urandom_range(0, 20));
    h[9:0]   = 10'($urandom_range(0, 1023));
    return h;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = rand_lane();
    return v;
  endfunction

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  // ---------------- stimulus helpers (called on a falling edge) ----------------
  task automatic send_vec(input logic [255:0] v, input logic [15:0] m);
    int budget;
    budget   = 0;
    in_vec   = v;
    in_mask  = m;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end else begin
      exp_q.push_back(model_reduce(v, m));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 300);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_vec = '0; in_mask = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int cyc;
    logic [15:0] e;
    out_ready = 1'b1;
    send_vec({16{16'h3C00}}, 16'hFFFF);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ones_busy got=%b exp=1", busy); end
    wait_out(cyc);
    e = pop_exp();
    checks++; if (cyc != 15) begin failures++; $display("FAIL ones_latency got=%0d exp=15", cyc); end
    checks++; if (sum !== e) begin failures++; $display("FAIL ones_sum got=%h exp=%h", sum, e); end
    checks++; if (sum !== 16'h4C00) begin failures++; $display("FAIL ones_sum_lit got=%h exp=4c00", sum); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_mask_half();
    int cyc;
    logic [15:0] e;
    send_vec({16{16'h3800}}, 16'h00FF);
    wait_out(cyc);
    e = pop_exp();
    checks++; if (cyc != 15) begin failures++; $display("FAIL half_latency got=%0d exp=15", cyc); end
    checks++; if (sum !== e) begin failures++; $display("FAIL half_sum got=%h exp=%h", sum, e); end
    checks++; if (sum !== 16'h4400) begin failures++; $display("FAIL half_sum_lit got=%h exp=4400", sum); end
    @(negedge clk);
  endtask

  task automatic test_cancel_and_zero_mask();
    int cyc;
    logic [15:0]  e;
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = (i % 2 == 1) ? 16'hBC00 : 16'h3C00;
    send_vec(v, 16'hFFFF);
    wait_out(cyc);
    e = pop_exp();
    checks++; if (sum !== e || sum !== 16'h0000) begin failures++; $display("FAIL cancel_sum got=%h exp=%h", sum, e); end
    @(negedge clk);
    send_vec(rand_vec(), 16'h0000);
    wait_out(cyc);
    e = pop_exp();
    checks++; if (sum !== e || sum !== 16'h0000) begin failures++; $display("FAIL zero_mask_sum got=%h exp=%h", sum, e); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [15:0] e;
    out_ready = 1'b0;
    send_vec({16{16'h3C00}}, 16'hFFFF);
    wait_out(cyc);
    e = pop_exp();
    checks++; if (out_valid !== 1'b1 || sum !== e) begin failures++; $display("FAIL bp_first valid=%b sum=%h exp=%h", out_valid, sum, e); end
    for (int k = 0; k < 10; k++) begin
      in_vec = rand_vec(); in_mask = 16'hFFFF; in_valid = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid k=%0d got=%b exp=1", k, out_valid); end
      checks++; if (sum !== e) begin failures++; $display("FAIL bp_hold_sum k=%0d got=%h exp=%h", k, sum, e); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b ready=%b exp 0/1", out_valid, in_ready); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_extra_accept qsize=%0d exp=0", exp_q.size()); end
    send_vec({16{16'h3C00}}, 16'hFFFF);
    wait_out(cyc);
    e = pop_exp();
    checks++; if (sum !== e || sum !== 16'h4C00) begin failures++; $display("FAIL bp_next_sum got=%h exp=%h", sum, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    logic [15:0] e;
    out_ready = 1'b1;
    send_vec({16{16'h3C00}}, 16'hFFFF);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    e = pop_exp();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL rstmid_sum got=%h exp=0000", sum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_spurious got=%0d exp=0", seen); end
    send_vec(rand_vec(), 16'($urandom_range(0, 65535)));
    wait_out(cyc);
    e = pop_exp();
    checks++; if (sum !== e) begin failures++; $display("FAIL rstmid_next_sum got=%h exp=%h", sum, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int got;
    int cyc;
    logic        r;
    logic [15:0] e;
    got = 0;
    cyc = 0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          send_vec(rand_vec(), (n % 4 == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535)));
        end
      end
      begin
        while (got < 100 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          r = ($urandom_range(0, 3) != 0);
          out_ready = r;
          if (out_valid === 1'b1 && r) begin
            e = pop_exp();
            checks++;
            if (sum !== e) begin failures++; $display("FAIL b2b_sum idx=%0d got=%h exp=%h", got, sum, e); end
            got++;
          end
        end
      end
    join
    checks++; if (got != 100) begin failures++; $display("FAIL b2b_count got=%0d exp=100", got); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_mask_half();
    test_cancel_and_zero_mask();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
